// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: registered 2-cycle multiply path and a
// 32-iteration restoring divider, with busy/done handshake to the pipeline.
module muldiv_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [OP_WIDTH-1:0]   op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned CNT_W = 6;
    localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [1:0]         op_q;      // [1]: rem/high-half select, [0]: sign variant
    logic [DW-1:0]      a_q;       // multiplicand, or quotient while dividing
    logic [DW-1:0]      b_q;       // multiplier, or divisor while dividing
    logic [DW-1:0]      rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               negq_q;
    logic               negr_q;

    // op_i[3] is zero for every M-extension code; it carries no information here
    logic unused_op_bit;
    assign unused_op_bit = op_i[3];

    // Request decode and special-case detection for the accepting edge
    logic          accept;
    logic          sgn_i;
    logic          a_neg;
    logic          b_neg;
    logic [DW-1:0] a_abs;
    logic [DW-1:0] b_abs;
    logic          div_zero;
    logic          div_ovf;
    logic [DW-1:0] special_res;

    always_comb begin
        accept      = (state_q == S_IDLE) && start_i && op_i[4] && !flush_i;
        sgn_i       = ~op_i[0];
        a_neg       = sgn_i & a_i[DW-1];
        b_neg       = sgn_i & b_i[DW-1];
        a_abs       = a_neg ? -a_i : a_i;
        b_abs       = b_neg ? -b_i : b_i;
        div_zero    = (b_i == '0);
        div_ovf     = sgn_i && (a_i == MIN_NEG) && (b_i == ALL_ONES);
        special_res = '0;
        if (div_zero) begin
            special_res = op_i[1] ? a_i : ALL_ONES;
        end else if (div_ovf) begin
            special_res = op_i[1] ? '0 : MIN_NEG;
        end
    end

    // Multiply: sign-extend per variant, keep low or high half of the product
    logic                sa;
    logic                sb;
    logic [2*DW-1:0]     a_ext;
    logic [2*DW-1:0]     b_ext;
    logic [2*DW-1:0]     prod;
    logic [DW-1:0]       mul_res;

    always_comb begin
        sa      = (op_q == 2'b01) || (op_q == 2'b10);
        sb      = (op_q == 2'b01);
        a_ext   = {{DW{sa & a_q[DW-1]}}, a_q};
        b_ext   = {{DW{sb & b_q[DW-1]}}, b_q};
        prod    = a_ext * b_ext;
        mul_res = (op_q == 2'b00) ? prod[DW-1:0] : prod[2*DW-1:DW];
    end

    // One restoring-division step; the 33-bit trial value lives only here
    logic [DW:0]   rem_sh;
    logic [DW:0]   rem_diff;
    logic          ge;
    logic [DW-1:0] rem_nx;
    logic [DW-1:0] quo_nx;
    logic [DW-1:0] fix_res;

    always_comb begin
        rem_sh   = {rem_q, a_q[DW-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        ge       = (rem_sh >= {1'b0, b_q});
        rem_nx   = ge ? rem_diff[DW-1:0] : rem_sh[DW-1:0];
        quo_nx   = {a_q[DW-2:0], ge};
        if (op_q[1]) begin
            fix_res = negr_q ? -rem_q : rem_q;
        end else begin
            fix_res = negq_q ? -a_q : a_q;
        end
    end

    // Sequencer state, datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            res_o   <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state_q <= S_IDLE;
                busy_o  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            op_q   <= op_i[1:0];
                            negq_q <= a_neg ^ b_neg;
                            negr_q <= a_neg;
                            busy_o <= 1'b1;
                            if (!op_i[2]) begin
                                a_q     <= a_i;
                                b_q     <= b_i;
                                state_q <= S_MUL;
                            end else if (div_zero || div_ovf) begin
                                res_o   <= special_res;
                                done_o  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                a_q     <= a_abs;
                                b_q     <= b_abs;
                                rem_q   <= '0;
                                cnt_q   <= CNT_W'(DW);
                                state_q <= S_DIV;
                            end
                        end
                    end
                    S_MUL: begin
                        res_o   <= mul_res;
                        done_o  <= 1'b1;
                        state_q <= S_DONE;
                    end
                    S_DIV: begin
                        a_q   <= quo_nx;
                        rem_q <= rem_nx;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        res_o   <= fix_res;
                        done_o  <= 1'b1;
                        state_q <= S_DONE;
                    end
                    S_DONE: begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, latencies, flush and reset abort.
`timescale 1ns/1ps
module tb_muldiv_seq;

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [4:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] res_o;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .res_o   (res_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then measure edges from acceptance to done_o and check the result
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, res_o, exp_res);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd1);
        @(posedge clk);
        #1;
        check_eq({tag, "_idle"}, 32'({busy_o, done_o}), 32'd0);
    endtask

    initial begin
        int lat;
        int dones;
        rst_n   = 1'b0;
        start_i = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        flush_i = 1'b0;
        #12;
        check_eq("reset_busy", 32'(busy_o), 32'd0);
        check_eq("reset_done", 32'(done_o), 32'd0);
        check_eq("reset_res", res_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiplies
        run_op("mul",    OP_MUL,    32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0000);
        run_op("mulhu",  OP_MULHU,  32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0001);
        run_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 1, 32'hFFFF_FFFF);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
        run_op("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000);

        // Divides
        run_op("div",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run_op("rem",  OP_REM,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 33, 32'd14);
        run_op("remu", OP_REMU, 32'd100, 32'd7, 33, 32'd2);

        // Special cases resolved on the accepting edge
        run_op("divu_z",  OP_DIVU, 32'h0000_1234, 32'd0, 0, 32'hFFFF_FFFF);
        run_op("rem_z",   OP_REM,  32'h0000_1234, 32'd0, 0, 32'h0000_1234);
        run_op("div_ovf", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
        run_op("rem_ovf", OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000);

        // Non-M op codes never start the sequencer
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 5'b00101;
        a_i     = 32'd9;
        b_i     = 32'd3;
        @(posedge clk);
        #1;
        check_eq("ignored_busy", 32'({busy_o, done_o}), 32'd0);
        @(posedge clk);
        #1;
        check_eq("ignored_busy2", 32'({busy_o, done_o}), 32'd0);
        start_i = 1'b0;

        // start_i held through a divide: second request waits until after DONE
        @(negedge clk);
        start_i = 1'b1;
        op_i    = OP_DIVU;
        a_i     = 32'd100;
        b_i     = 32'd7;
        @(posedge clk);
        #1;
        op_i = OP_DIVU;
        a_i  = 32'd50;
        b_i  = 32'd3;
        lat = 0;
        while (!done_o && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("hold_lat1", 32'(lat), 32'd33);
        check_eq("hold_res1", res_o, 32'd14);
        @(posedge clk);
        #1;
        check_eq("hold_gap", 32'({busy_o, done_o}), 32'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check_eq("hold_accept2", 32'(busy_o), 32'd1);
        lat = 0;
        while (!done_o && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("hold_lat2", 32'(lat), 32'd33);
        check_eq("hold_res2", res_o, 32'd16);
        @(posedge clk);
        #1;

        // Flush on iteration 10: back to IDLE, result register untouched
        @(negedge clk);
        start_i = 1'b1;
        op_i    = OP_DIVU;
        a_i     = 32'd1000;
        b_i     = 32'd9;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("flush_busy", 32'({busy_o, done_o}), 32'd0);
        check_eq("flush_res", res_o, 32'd16);
        @(negedge clk);
        flush_i = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o || busy_o) dones++;
        end
        check_eq("flush_quiet", 32'(dones), 32'd0);

        // Reset mid-divide takes effect without a clock edge
        @(negedge clk);
        start_i = 1'b1;
        op_i    = OP_DIV;
        a_i     = 32'd77;
        b_i     = 32'd5;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'({busy_o, done_o}), 32'd0);
        check_eq("rst_res", res_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("post_rst", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer for the RV32M multiply/divide datapath.
- Replaces the single-cycle `/` and `%` operators with a 32-iteration restoring divider. Multiplies run through a registered 2-cycle path.
- Sits beside the main ALU in the execute stage. It drives `busy_o` so the pipeline stalls until `done_o` pulses, then the pipeline takes `res_o`.

Parameters:
- DATA_WIDTH, 32, operand and result width. Only 32 is supported.
- OP_WIDTH, 5, ALU op-code width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start_i  input  1  request; sampled only when busy_o=0.
- op_i  input  5  op code: 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- a_i  input  32  rs1 operand; sampled with start_i.
- b_i  input  32  rs2 operand; sampled with start_i.
- flush_i  input  1  synchronous abort from pipeline flush.
- busy_o  output  1  high whenever state != IDLE.
- done_o  output  1  one-cycle pulse; res_o is valid in this cycle.
- res_o  output  32  registered result; holds until the next done_o.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy_o=0, done_o=0, res_o=0.
  - Counter, quotient and remainder registers cleared.
- Acceptance (edge E0): state=IDLE, start_i=1, op_i[4]=1 and flush_i=0.
  - Operands and op are latched.
  - Requests with op_i[4]=0 are ignored: no busy_o, no done_o.
  - start_i while busy_o=1, including the DONE cycle, is ignored.
- States:
  - IDLE -> MUL: accepted multiply.
  - IDLE -> DIV: accepted divide/remainder, non-special case.
  - IDLE -> DONE: divide special case.
  - MUL -> DONE after 1 cycle.
  - DIV -> FIX when the count reaches 0.
  - FIX -> DONE.
  - DONE -> IDLE.
- MUL state:
  - Forms the 64-bit product: signed x signed (MULH), signed x unsigned (MULHSU), unsigned x unsigned (MUL, MULHU).
  - MUL registers bits [31:0]; the other three register bits [63:32].
  - Result is registered at E1; done_o is high between E1 and E2.
- DIV load at E0:
  - Divisor |b| (signed ops) or b (unsigned ops).
  - Quotient register = |a| or a; 33-bit remainder = 0; count = 32.
  - Record negq = sign(a) XOR sign(b) and negr = sign(a), signed ops only.
- DIV iteration (edges E1..E32), one per cycle:
  - rem = {rem[31:0], q[31]}; q <<= 1.
  - If rem >= divisor: rem -= divisor, q[0] = 1.
  - Count decrements; the transition to FIX happens at E32.
- FIX (edge E33):
  - DIV/DIVU: res_o = negq ? -q : q.
  - REM/REMU: res_o = negr ? -rem : rem.
  - done_o is high between E33 and E34.
- Special divide cases, resolved at E0 straight into DONE (done_o between E0 and E1):
  - b=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Latency from the accepting edge to done_o: MUL 1, DIV 33, special case 0 (all in edges).
- flush_i=1 at any edge:
  - Next state is IDLE, no done_o, res_o unchanged.
  - Flush has priority over start_i and over a DONE completion.
  - Flush arriving in the DONE cycle suppresses nothing already pulsed.
- Reset asserted mid-operation aborts immediately to the reset values.
- A new start is accepted in the first IDLE cycle after DONE; there is no back-to-back acceptance in the DONE cycle.

Test Plan:
- Reset, then MUL a=0x00010000, b=0x00010000 -> done_o 2 cycles after start; res_o=0x00000000. Same operands with MULHU -> res_o=0x00000001.
- MULH a=0xFFFFFFFF(-1), b=0x00000002 -> 0xFFFFFFFF. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done_o exactly 33 edges after the accepting edge; res_o=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- DIVU b=0, a=0x1234 -> 0xFFFFFFFF. REM b=0 -> 0x1234. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. All three: done_o in the cycle after acceptance, busy_o high for 1 cycle.
- start_i held high with new operands during a DIV -> ignored; result matches the first request; the second request is accepted only after the DONE cycle.
- flush_i at iteration 10 of a DIV -> IDLE next cycle, no done_o, res_o keeps its prior value. rst_n low at iteration 20 -> busy_o=0 and res_o=0 immediately, without waiting for a clock edge.
